lsu_unalign_seq: RTL and testbench

LSU_UNALIGN_SEQ -- requirements
Module: lsu_unalign_seq

---
 rtl/lsu_unalign_seq.sv | 199 +++++++++++++++++++
 tb/tb_lsu_unalign_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unalign_seq.sv
`timescale 1ns/1ps
// Unaligned external load/store sequencer: splits an access crossing a word boundary into two bus sub-accesses.
// Optional RV_LSU_SPLIT_ABORT_EN: an error on the first half of a split access skips the second half.
module lsu_unalign_seq #(
    parameter int TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        rsp_valid,
    input  logic        rsp_err,
    input  logic [31:0] rsp_rdata,
    output logic        done_valid,
    output logic        done_err,
    output logic [31:0] done_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ISS0, WAIT0, ISS1, WAIT1, DONE} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TMO_CYCLES);

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        split_q;
    logic [3:0]  hi_be_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] addr_lo_q;
    logic [31:0] buf_lo;
    logic [31:0] buf_hi;
    logic        err_q;
    logic [7:0]  tmo_cnt;

    logic [3:0]  size_mask;
    logic [7:0]  req_mask;
    logic [63:0] req_wdata_sh;
    logic        is_wait;
    logic        tmo_hit;
    logic        rsp_take;
    logic        eff_err;
    logic [31:0] eff_data;
    logic        abort_split;
    logic        go_iss1;

    always_comb begin
        size_mask = 4'hF;
        case (req_size)
            2'd0:    size_mask = 4'h1;
            2'd1:    size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    end

    assign req_mask     = {4'b0000, size_mask} << req_addr[1:0];
    assign req_wdata_sh = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};

    // A timeout stands in for a response carrying an error and zero data.
    assign is_wait  = (state == WAIT0) || (state == WAIT1);
    assign tmo_hit  = is_wait && (tmo_cnt == TMO_LIMIT);
    assign rsp_take = is_wait && (tmo_hit || rsp_valid);
    assign eff_err  = tmo_hit || rsp_err;
    assign eff_data = tmo_hit ? 32'b0 : rsp_rdata;

`ifdef RV_LSU_SPLIT_ABORT_EN
    assign abort_split = eff_err;
`else
    assign abort_split = 1'b0;
`endif
    assign go_iss1 = split_q && !abort_split;

    function automatic logic [31:0] align_load(input logic [63:0] pair, input logic [1:0] off,
                                               input logic [1:0] size, input logic is_write);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'd0:    res = {24'b0, sh[7:0]};
            2'd1:    res = {16'b0, sh[15:0]};
            default: res = sh;
        endcase
        if (is_write) res = 32'b0;
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            bus_valid  <= 1'b0;
            bus_addr   <= 32'b0;
            bus_write  <= 1'b0;
            bus_wdata  <= 32'b0;
            bus_byteen <= 4'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            done_rdata <= 32'b0;
            off_q      <= 2'b0;
            size_q     <= 2'b0;
            write_q    <= 1'b0;
            split_q    <= 1'b0;
            hi_be_q    <= 4'b0;
            wdata_hi_q <= 32'b0;
            addr_lo_q  <= 32'b0;
            buf_lo     <= 32'b0;
            buf_hi     <= 32'b0;
            err_q      <= 1'b0;
            tmo_cnt    <= 8'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= ISS0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        write_q    <= req_write;
                        split_q    <= |req_mask[7:4];
                        hi_be_q    <= req_mask[7:4];
                        wdata_hi_q <= req_wdata_sh[63:32];
                        addr_lo_q  <= {req_addr[31:2], 2'b00};
                        buf_lo     <= 32'b0;
                        buf_hi     <= 32'b0;
                        err_q      <= 1'b0;
                        bus_valid  <= 1'b1;
                        bus_addr   <= {req_addr[31:2], 2'b00};
                        bus_write  <= req_write;
                        bus_wdata  <= req_wdata_sh[31:0];
                        bus_byteen <= req_mask[3:0];
                    end
                end
                ISS0, ISS1: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        tmo_cnt   <= 8'b0;
                        state     <= (state == ISS0) ? WAIT0 : WAIT1;
                    end
                end
                WAIT0: begin
                    if (rsp_take) begin
                        buf_lo <= eff_data;
                        err_q  <= err_q | eff_err;
                        if (go_iss1) begin
                            state      <= ISS1;
                            bus_valid  <= 1'b1;
                            bus_addr   <= addr_lo_q + 32'd4;
                            bus_wdata  <= wdata_hi_q;
                            bus_byteen <= hi_be_q;
                        end else begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                            done_err   <= err_q | eff_err;
                            done_rdata <= align_load({buf_hi, eff_data}, off_q, size_q, write_q);
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WAIT1: begin
                    if (rsp_take) begin
                        buf_hi     <= eff_data;
                        err_q      <= err_q | eff_err;
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_err   <= err_q | eff_err;
                        done_rdata <= align_load({eff_data, buf_lo}, off_q, size_q, write_q);
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Ready rises only on return to IDLE, so no request is taken during the done pulse.
                    state      <= IDLE;
                    done_valid <= 1'b0;
                    done_err   <= 1'b0;
                    done_rdata <= 32'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unalign_seq.sv
`timescale 1ns/1ps
// Directed testbench for lsu_unalign_seq (TMO_CYCLES = 4).
module tb_lsu_unalign_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        done_valid;
    logic        done_err;
    logic [31:0] done_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Results captured by the bus/response driver
    int          nbus;
    logic [31:0] log_addr [4];
    logic [3:0]  log_be   [4];
    logic [31:0] log_wd   [4];
    logic        log_wr   [4];
    int          lat;
    logic        d_seen;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        d_ready;
    int          stab_bad;

    lsu_unalign_seq #(.TMO_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .done_valid(done_valid), .done_err(done_err), .done_rdata(done_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Issues one request and services the bus; latency counts the accept cycle as cycle 1.
    task automatic run_access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                              input logic [31:0] wd, input logic [31:0] r0, input logic e0,
                              input logic [31:0] r1, input logic e1, input logic respond,
                              input int stall);
        int sc;
        logic pend;
        logic [31:0] ha;
        logic [3:0]  hb;
        logic [31:0] hw;
        nbus = 0; d_seen = 0; lat = 0; stab_bad = 0;
        d_err = 0; d_rdata = 0; d_ready = 0; pend = 0; sc = 0;
        ha = 0; hb = 0; hw = 0;
        @(negedge clk);
        req_valid = 1; req_addr = a; req_size = sz; req_write = wr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        for (int cyc = 2; cyc < 60 && !d_seen; cyc++) begin
            if (done_valid) begin
                d_seen = 1; lat = cyc; d_err = done_err; d_rdata = done_rdata; d_ready = req_ready;
            end else begin
                rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; bus_ready = 0;
                if (pend) begin
                    pend = 0;
                    if (respond) begin
                        rsp_valid = 1;
                        rsp_rdata = (nbus == 1) ? r0 : r1;
                        rsp_err   = (nbus == 1) ? e0 : e1;
                    end
                end
                if (bus_valid) begin
                    if (sc == 0) begin
                        ha = bus_addr; hb = bus_byteen; hw = bus_wdata;
                    end else if (bus_addr !== ha || bus_byteen !== hb || bus_wdata !== hw) begin
                        stab_bad++;
                    end
                    if (sc < stall) begin
                        sc++;
                    end else begin
                        bus_ready = 1;
                        if (nbus < 4) begin
                            log_addr[nbus] = bus_addr; log_be[nbus] = bus_byteen;
                            log_wd[nbus] = bus_wdata; log_wr[nbus] = bus_write;
                        end
                        nbus++;
                        pend = 1;
                        sc = 0;
                    end
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; bus_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        tests++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid got=%b exp=0", bus_valid); end
        tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
        tests++; if (done_err !== 1'b0) begin fails++; $display("FAIL reset_done_err got=%b exp=0", done_err); end
        tests++; if (done_rdata !== 32'h0) begin fails++; $display("FAIL reset_done_rdata got=%h exp=0", done_rdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        run_access(32'h1000, 2'd2, 1'b0, 32'h0, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        tests++; if (!d_seen) begin fails++; $display("FAIL word_done got=none exp=done_valid"); end
        tests++; if (nbus != 1) begin fails++; $display("FAIL word_nbus got=%0d exp=1", nbus); end
        tests++; if (log_addr[0] !== 32'h1000 || log_be[0] !== 4'hF || log_wr[0] !== 1'b0) begin
            fails++; $display("FAIL word_bus got=%h/%h/%b exp=00001000/f/0", log_addr[0], log_be[0], log_wr[0]); end
        tests++; if (d_rdata !== 32'hAABBCCDD) begin fails++; $display("FAIL word_rdata got=%h exp=aabbccdd", d_rdata); end
        tests++; if (d_err !== 1'b0) begin fails++; $display("FAIL word_err got=%b exp=0", d_err); end
        tests++; if (lat != 4) begin fails++; $display("FAIL word_latency got=%0d exp=4", lat); end
        tests++; if (d_ready !== 1'b0) begin fails++; $display("FAIL word_ready_in_done got=%b exp=0", d_ready); end
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL word_idle_after got=%b/%b exp=1/0", req_ready, busy); end
    endtask

    task automatic test_sizes();
        run_access(32'h1003, 2'd0, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        tests++; if (nbus != 1 || log_be[0] !== 4'h8 || d_rdata !== 32'h000000A1 || lat != 4) begin
            fails++; $display("FAIL byte_load got=%0d/%h/%h/%0d exp=1/8/000000a1/4", nbus, log_be[0], d_rdata, lat); end
        run_access(32'h2000, 2'd3, 1'b0, 32'h0, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        tests++; if (nbus != 1 || log_be[0] !== 4'hF || d_rdata !== 32'h12345678) begin
            fails++; $display("FAIL size3_word got=%0d/%h/%h exp=1/f/12345678", nbus, log_be[0], d_rdata); end
    endtask

    task automatic test_split_load();
        run_access(32'h1003, 2'd1, 1'b0, 32'h0, 32'h11223344, 1'b0, 32'h55667788, 1'b0, 1'b1, 2);
        tests++; if (nbus != 2) begin fails++; $display("FAIL split_nbus got=%0d exp=2", nbus); end
        tests++; if (log_addr[0] !== 32'h1000 || log_be[0] !== 4'h8) begin
            fails++; $display("FAIL split_bus0 got=%h/%h exp=00001000/8", log_addr[0], log_be[0]); end
        tests++; if (log_addr[1] !== 32'h1004 || log_be[1] !== 4'h1) begin
            fails++; $display("FAIL split_bus1 got=%h/%h exp=00001004/1", log_addr[1], log_be[1]); end
        tests++; if (d_rdata !== 32'h00008811 || d_err !== 1'b0) begin
            fails++; $display("FAIL split_rdata got=%h/%b exp=00008811/0", d_rdata, d_err); end
        tests++; if (stab_bad != 0) begin fails++; $display("FAIL split_stall_stable got=%0d exp=0", stab_bad); end
        tests++; if (lat != 10) begin fails++; $display("FAIL split_stall_latency got=%0d exp=10", lat); end
        run_access(32'h1002, 2'd2, 1'b0, 32'h0, 32'h44332211, 1'b0, 32'h88776655, 1'b0, 1'b1, 0);
        tests++; if (d_rdata !== 32'h66554433 || lat != 6 || nbus != 2) begin
            fails++; $display("FAIL split_word got=%h/%0d/%0d exp=66554433/6/2", d_rdata, lat, nbus); end
    endtask

    task automatic test_store_wrap();
        run_access(32'hFFFFFFFE, 2'd2, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 0);
        tests++; if (nbus != 2) begin fails++; $display("FAIL store_nbus got=%0d exp=2", nbus); end
        tests++; if (log_addr[0] !== 32'hFFFFFFFC || log_be[0] !== 4'hC || log_wd[0] !== 32'hBEEF0000 || log_wr[0] !== 1'b1) begin
            fails++; $display("FAIL store_bus0 got=%h/%h/%h/%b exp=fffffffc/c/beef0000/1", log_addr[0], log_be[0], log_wd[0], log_wr[0]); end
        tests++; if (log_addr[1] !== 32'h0 || log_be[1] !== 4'h3 || log_wd[1] !== 32'h0000DEAD || log_wr[1] !== 1'b1) begin
            fails++; $display("FAIL store_bus1 got=%h/%h/%h/%b exp=00000000/3/0000dead/1", log_addr[1], log_be[1], log_wd[1], log_wr[1]); end
        tests++; if (d_rdata !== 32'h0 || d_err !== 1'b0) begin
            fails++; $display("FAIL store_done got=%h/%b exp=00000000/0", d_rdata, d_err); end
    endtask

    task automatic test_split_err();
        run_access(32'h1003, 2'd1, 1'b0, 32'h0, 32'h11223344, 1'b1, 32'h55667788, 1'b0, 1'b1, 0);
        tests++; if (!d_seen || d_err !== 1'b1) begin fails++; $display("FAIL split_err_flag got=%b/%b exp=1/1", d_seen, d_err); end
`ifdef RV_LSU_SPLIT_ABORT_EN
        tests++; if (nbus != 1 || lat != 4) begin fails++; $display("FAIL split_err_abort got=%0d/%0d exp=1/4", nbus, lat); end
`else
        tests++; if (nbus != 2 || lat != 6) begin fails++; $display("FAIL split_err_both got=%0d/%0d exp=2/6", nbus, lat); end
`endif
    endtask

    task automatic test_timeout();
        logic bad;
        run_access(32'h3000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        tests++; if (!d_seen || d_err !== 1'b1 || d_rdata !== 32'h0) begin
            fails++; $display("FAIL timeout_done got=%b/%b/%h exp=1/1/00000000", d_seen, d_err, d_rdata); end
        tests++; if (lat != 8) begin fails++; $display("FAIL timeout_latency got=%0d exp=8", lat); end
        bad = 0;
        rsp_valid = 1; rsp_err = 1; rsp_rdata = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            if (done_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        rsp_valid = 0; rsp_err = 0; rsp_rdata = 0;
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL timeout_late_rsp got=%b exp=0", bad); end
    endtask

    task automatic test_rst_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h1003; req_size = 2'd1; req_write = 0; req_wdata = 0;
        @(posedge clk); @(negedge clk);
        req_valid = 0; bus_ready = 1;
        @(posedge clk); @(negedge clk);
        bus_ready = 0; rsp_valid = 1; rsp_rdata = 32'h11223344;
        @(posedge clk); @(negedge clk);
        rsp_valid = 0; bus_ready = 1;
        tests++; if (bus_valid !== 1'b1 || bus_addr !== 32'h1004) begin
            fails++; $display("FAIL rstmid_iss1 got=%b/%h exp=1/00001004", bus_valid, bus_addr); end
        @(posedge clk); @(negedge clk);
        bus_ready = 0;
        rst = 1;
        #1;
        tests++; if (bus_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_state got=%b/%b/%b exp=0/0/1", bus_valid, busy, req_ready); end
        @(negedge clk);
        rst = 0;
        seen = 0;
        rsp_valid = 1; rsp_rdata = 32'h55667788;
        repeat (3) begin
            @(negedge clk);
            if (done_valid !== 1'b0) seen = 1;
        end
        rsp_valid = 0; rsp_rdata = 0;
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
        run_access(32'h1000, 2'd2, 1'b0, 32'h0, 32'h01020304, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        tests++; if (!d_seen || d_rdata !== 32'h01020304 || d_err !== 1'b0 || lat != 4) begin
            fails++; $display("FAIL rstmid_next got=%b/%h/%b/%0d exp=1/01020304/0/4", d_seen, d_rdata, d_err, lat); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req_valid = 0; req_addr = 0; req_size = 0; req_write = 0; req_wdata = 0;
        bus_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0;
        test_reset();
        test_word_load();
        test_sizes();
        test_split_load();
        test_store_wrap();
        test_split_err();
        test_timeout();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
